// File: rtl/aud_record_writer.sv
// -----------------------------------------------------------------------------
// aud_record_writer
//
// Record path for the codec's ADC. Takes the I2S bit stream on the bit clock,
// keeps one channel, and writes each finished 16-bit sample to SRAM with a
// single-cycle write strobe at an address that counts up from zero. The
// controller starts, pauses, resumes and stops recording. It reads back the
// number of samples written so playback knows how much to play.
//
// Ports
//   i_clk        codec bit clock (BCLK); all logic runs on its rising edge
//   i_rst_n      asynchronous active-low reset
//   i_lrc        ADC LR clock from the codec
//   i_adc_dat    ADC serial data, MSB first
//   i_start      level: start a new recording (from IDLE) or resume (from PAUSE)
//   i_pause      level: pause request
//   i_stop       level: stop request
//   o_sram_addr  SRAM word address for the write
//   o_sram_data  SRAM write data
//   o_sram_we    write strobe, high for one cycle per sample
//   o_length     samples written since the last start from IDLE
//   o_busy       high in every state except IDLE
//   o_full       sticky: recording ended because MAX_ADDR was written
// -----------------------------------------------------------------------------
module aud_record_writer #(
    parameter bit          CHANNEL  = 1'b0,      // LRC level of captured channel
    parameter logic [19:0] MAX_ADDR = 20'hFFFFF  // last writable word address
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_lrc,
    input  logic        i_adc_dat,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_stop,
    output logic [19:0] o_sram_addr,
    output logic [15:0] o_sram_data,
    output logic        o_sram_we,
    output logic [20:0] o_length,
    output logic        o_busy,
    output logic        o_full
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_LRC,
        ST_SHIFT,
        ST_WRITE,
        ST_PAUSE
    } state_t;

    state_t      state_q,      state_d;
    logic        lrc_dly_q,    lrc_dly_d;
    logic [3:0]  bit_cnt_q,    bit_cnt_d;
    logic [15:0] shift_q,      shift_d;
    logic        pause_pend_q, pause_pend_d;
    logic [19:0] addr_q,       addr_d;
    logic [15:0] data_q,       data_d;
    logic        we_q,         we_d;
    logic [20:0] length_q,     length_d;
    logic        full_q,       full_d;

    logic frame_edge;

    // First cycle of the captured channel's LRC phase. In I2S this cycle is the
    // one-bit delay slot, so its data bit is not part of the sample.
    assign frame_edge = (i_lrc == CHANNEL) && (lrc_dly_q != CHANNEL);

    always_comb begin
        // NOTE: every signal assigned below gets a default first, so paths that
        // do not touch it hold state instead of inferring a latch.
        state_d      = state_q;
        lrc_dly_d    = i_lrc;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        pause_pend_d = pause_pend_q;
        addr_d       = addr_q;
        data_d       = data_q;
        we_d         = 1'b0;
        length_d     = length_q;
        full_d       = full_q;

        unique case (state_q)
            ST_IDLE: begin
                // Address, length and full hold in IDLE until the next start.
                // A start clears them.
                if (i_start && !i_stop && !i_pause) begin
                    state_d      = ST_WAIT_LRC;
                    addr_d       = '0;
                    length_d     = '0;
                    full_d       = 1'b0;
                    pause_pend_d = 1'b0;
                end
            end

            ST_WAIT_LRC: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                end else if (i_pause) begin
                    state_d = ST_PAUSE;
                end else if (frame_edge) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                end
            end

            ST_SHIFT: begin
                if (i_stop) begin
                    // Drop the partial sample. Nothing is written.
                    state_d      = ST_IDLE;
                    pause_pend_d = 1'b0;
                end else begin
                    shift_d   = {shift_q[14:0], i_adc_dat};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (i_pause) begin
                        pause_pend_d = 1'b1;
                    end
                    if (bit_cnt_q == 4'd15) begin
                        // The strobe is registered, so it is high exactly
                        // during the WRITE cycle.
                        state_d = ST_WRITE;
                        data_d  = {shift_q[14:0], i_adc_dat};
                        we_d    = 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                length_d     = length_q + 21'd1;
                pause_pend_d = 1'b0;
                if (addr_q == MAX_ADDR) begin
                    full_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    addr_d = addr_q + 20'd1;
                    if (i_stop) begin
                        state_d = ST_IDLE;
                    end else if (pause_pend_q || i_pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_WAIT_LRC;
                    end
                end
            end

            ST_PAUSE: begin
                // Resume through WAIT_LRC so capture starts on a clean frame.
                if (i_stop) begin
                    state_d = ST_IDLE;
                end else if (i_start && !i_pause) begin
                    state_d = ST_WAIT_LRC;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            lrc_dly_q    <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            pause_pend_q <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            we_q         <= 1'b0;
            length_q     <= '0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lrc_dly_q    <= lrc_dly_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            pause_pend_q <= pause_pend_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            we_q         <= we_d;
            length_q     <= length_d;
            full_q       <= full_d;
        end
    end

    assign o_sram_addr = addr_q;
    assign o_sram_data = data_q;
    assign o_sram_we   = we_q;
    assign o_length    = length_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_full      = full_q;

endmodule

// File: tb/tb_aud_record_writer.sv
// -----------------------------------------------------------------------------
// Testbench for aud_record_writer (CHANNEL = 0, MAX_ADDR = 3).
// Stimulus drives whole I2S frames. Each expected SRAM write is pushed to a
// scoreboard queue. A monitor pops an entry on every write strobe and compares
// the address and data. A strobe with no matching entry is reported.
// -----------------------------------------------------------------------------
module tb_aud_record_writer;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_lrc;
    logic        i_adc_dat;
    logic        i_start;
    logic        i_pause;
    logic        i_stop;
    logic [19:0] o_sram_addr;
    logic [15:0] o_sram_data;
    logic        o_sram_we;
    logic [20:0] o_length;
    logic        o_busy;
    logic        o_full;

    aud_record_writer #(
        .CHANNEL  (1'b0),
        .MAX_ADDR (20'd3)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_lrc       (i_lrc),
        .i_adc_dat   (i_adc_dat),
        .i_start     (i_start),
        .i_pause     (i_pause),
        .i_stop      (i_stop),
        .o_sram_addr (o_sram_addr),
        .o_sram_data (o_sram_data),
        .o_sram_we   (o_sram_we),
        .o_length    (o_length),
        .o_busy      (o_busy),
        .o_full      (o_full)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t sb[$];
    wr_t mon_exp;
    int  compared   = 0;
    int  mismatched = 0;

    localparam logic [2:0] C_NONE  = 3'b000;
    localparam logic [2:0] C_STOP  = 3'b001;
    localparam logic [2:0] C_PAUSE = 3'b010;
    localparam logic [2:0] C_START = 3'b100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_ctl(input logic [2:0] c);
        i_stop  = c[0];
        i_pause = c[1];
        i_start = c[2];
    endtask

    // One-cycle control pulse, applied at a falling edge.
    task automatic pulse(input logic [2:0] c);
        @(negedge i_clk);
        drive_ctl(c);
        @(negedge i_clk);
        drive_ctl(C_NONE);
    endtask

    // One LRC half of 18 bit clocks: the delay slot, 16 data bits MSB first,
    // then one pad bit. When ctl_at matches a slot index, ctl is pulsed in that slot.
    task automatic send_half(input logic lrc_val, input logic [15:0] data,
                             input logic dbit, input int ctl_at, input logic [2:0] ctl);
        for (int i = 0; i < 18; i++) begin
            @(negedge i_clk);
            i_lrc = lrc_val;
            if (i == 0)       i_adc_dat = dbit;
            else if (i <= 16) i_adc_dat = data[16-i];
            else              i_adc_dat = 1'b0;
            if (i == ctl_at) drive_ctl(ctl);
            else             drive_ctl(C_NONE);
        end
    endtask

    task automatic send_frame(input logic [15:0] left, input logic [15:0] right,
                              input logic dbit, input int ctl_at, input logic [2:0] ctl);
        send_half(1'b0, left, dbit, ctl_at, ctl);
        send_half(1'b1, right, ~dbit, -1, C_NONE);
    endtask

    task automatic expect_wr(input logic [19:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: sample away from the rising edge.
    always @(negedge i_clk) begin
        if (i_rst_n && o_sram_we) begin
            if (sb.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                mon_exp = sb.pop_front();
                check("wr_addr", {12'd0, o_sram_addr}, {12'd0, mon_exp.addr});
                check("wr_data", {16'd0, o_sram_data}, {16'd0, mon_exp.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n   = 1'b0;
        i_lrc     = 1'b1;
        i_adc_dat = 1'b0;
        drive_ctl(C_NONE);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Reset state
        check("rst_addr",   {12'd0, o_sram_addr}, 32'd0);
        check("rst_data",   {16'd0, o_sram_data}, 32'd0);
        check("rst_we",     {31'd0, o_sram_we},   32'd0);
        check("rst_length", {11'd0, o_length},    32'd0);
        check("rst_busy",   {31'd0, o_busy},      32'd0);
        check("rst_full",   {31'd0, o_full},      32'd0);

        // Basic capture: the delay bit is 1 and must be ignored; the right
        // sample is never written.
        pulse(C_START);
        check("basic_busy", {31'd0, o_busy}, 32'd1);
        expect_wr(20'd0, 16'hA5C3);
        send_frame(16'hA5C3, 16'h1234, 1'b1, -1, C_NONE);
        check("basic_length", {11'd0, o_length},    32'd1);
        check("basic_addr",   {12'd0, o_sram_addr}, 32'd1);
        pulse(C_STOP);
        check("basic_idle",       {31'd0, o_busy},      32'd0);
        check("basic_len_hold",   {11'd0, o_length},    32'd1);
        check("basic_addr_hold",  {12'd0, o_sram_addr}, 32'd1);

        // Stream of four frames; with MAX_ADDR = 3 the fourth write also fills memory.
        pulse(C_START);
        check("stream_len_clr",  {11'd0, o_length},    32'd0);
        check("stream_addr_clr", {12'd0, o_sram_addr}, 32'd0);
        expect_wr(20'd0, 16'h0001);
        expect_wr(20'd1, 16'h8000);
        expect_wr(20'd2, 16'hFFFF);
        expect_wr(20'd3, 16'h7FFE);
        send_frame(16'h0001, 16'hBEEF, 1'b0, -1, C_NONE);
        send_frame(16'h8000, 16'hBEEF, 1'b1, -1, C_NONE);
        send_frame(16'hFFFF, 16'h0000, 1'b0, -1, C_NONE);
        send_frame(16'h7FFE, 16'hBEEF, 1'b1, -1, C_NONE);
        check("stream_length", {11'd0, o_length},    32'd4);
        check("stream_full",   {31'd0, o_full},      32'd1);
        check("stream_idle",   {31'd0, o_busy},      32'd0);

        // Full: six frames, only the first four are written.
        pulse(C_START);
        check("full_clr", {31'd0, o_full}, 32'd0);
        expect_wr(20'd0, 16'h1111);
        expect_wr(20'd1, 16'h2222);
        expect_wr(20'd2, 16'h3333);
        expect_wr(20'd3, 16'h4444);
        send_frame(16'h1111, 16'h9999, 1'b1, -1, C_NONE);
        send_frame(16'h2222, 16'h9999, 1'b0, -1, C_NONE);
        send_frame(16'h3333, 16'h9999, 1'b1, -1, C_NONE);
        send_frame(16'h4444, 16'h9999, 1'b0, -1, C_NONE);
        send_frame(16'h5555, 16'h9999, 1'b1, -1, C_NONE);
        send_frame(16'h6666, 16'h9999, 1'b0, -1, C_NONE);
        check("full_length", {11'd0, o_length},    32'd4);
        check("full_flag",   {31'd0, o_full},      32'd1);
        check("full_addr",   {12'd0, o_sram_addr}, 32'd3);
        check("full_idle",   {31'd0, o_busy},      32'd0);

        // Stop mid-shift after 8 bits of the second frame.
        pulse(C_START);
        expect_wr(20'd0, 16'hCAFE);
        send_frame(16'hCAFE, 16'h0F0F, 1'b1, -1, C_NONE);
        send_frame(16'hF00D, 16'h0F0F, 1'b0, 9, C_STOP);
        check("stop_idle",   {31'd0, o_busy},   32'd0);
        check("stop_length", {11'd0, o_length}, 32'd1);
        pulse(C_START);
        expect_wr(20'd0, 16'h1357);
        send_frame(16'h1357, 16'h0F0F, 1'b1, -1, C_NONE);
        check("restart_length", {11'd0, o_length}, 32'd1);
        pulse(C_STOP);

        // Pause pulsed at bit 5: the sample is still written, then nothing
        // is written for three frames. Resume lands mid-frame.
        pulse(C_START);
        expect_wr(20'd0, 16'h2468);
        send_frame(16'h2468, 16'h0F0F, 1'b0, 6, C_PAUSE);
        check("pause_busy",   {31'd0, o_busy},      32'd1);
        check("pause_addr",   {12'd0, o_sram_addr}, 32'd1);
        check("pause_length", {11'd0, o_length},    32'd1);
        for (int f = 0; f < 3; f++) begin
            send_frame(16'hEEEE, 16'hDDDD, 1'b1, -1, C_NONE);
        end
        check("pause_hold_len", {11'd0, o_length}, 32'd1);
        send_frame(16'hDEAD, 16'h0F0F, 1'b1, 8, C_START);
        expect_wr(20'd1, 16'h5A5A);
        send_frame(16'h5A5A, 16'h0F0F, 1'b0, -1, C_NONE);
        check("resume_length", {11'd0, o_length},    32'd2);
        check("resume_addr",   {12'd0, o_sram_addr}, 32'd2);
        pulse(C_STOP);

        // Asynchronous reset in the middle of a sample.
        pulse(C_START);
        expect_wr(20'd0, 16'hC0DE);
        send_frame(16'hC0DE, 16'h0F0F, 1'b1, -1, C_NONE);
        check("pre_rst_data", {16'd0, o_sram_data}, 32'h0000C0DE);
        for (int i = 0; i < 9; i++) begin
            @(negedge i_clk);
            i_lrc     = 1'b0;
            i_adc_dat = ~i_adc_dat;
        end
        #2;
        i_rst_n = 1'b0;
        i_lrc   = 1'b1;
        #1;
        check("arst_addr",   {12'd0, o_sram_addr}, 32'd0);
        check("arst_data",   {16'd0, o_sram_data}, 32'd0);
        check("arst_we",     {31'd0, o_sram_we},   32'd0);
        check("arst_length", {11'd0, o_length},    32'd0);
        check("arst_busy",   {31'd0, o_busy},      32'd0);
        check("arst_full",   {31'd0, o_full},      32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        pulse(C_START);
        expect_wr(20'd0, 16'h0F0F);
        send_frame(16'h0F0F, 16'hAAAA, 1'b0, -1, C_NONE);
        check("post_rst_length", {11'd0, o_length},    32'd1);
        check("post_rst_addr",   {12'd0, o_sram_addr}, 32'd1);
        pulse(C_STOP);

        repeat (4) @(negedge i_clk);
        check("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
